// File: rtl/select_debouncer.sv
// select_debouncer: turns one raw, bouncy board input into clean select
// signals (stable level, edge pulses and a press-toggle bit). The input is
// brought into the clk domain by a two-flop synchroniser. A four-state
// counter FSM then accepts a level change only after the synchronised input
// has held the new value for DEBOUNCE_CYCLES consecutive cycles.
module select_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_in,
  output logic sel_level,
  output logic sel_toggle,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Terminal count: a candidate is accepted when the counter reaches this
  // value and the input still disagrees with the current level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a_q;
  logic             sync_b_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sel_level_q;
  logic             sel_toggle_q;
  logic             rise_pulse_q;
  logic             fall_pulse_q;
  logic             busy_q;

  // Counter increment used while a candidate is being qualified.
  assign cnt_d = cnt_q + CNT_W'(1);

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_a_q <= 1'b0;
      sync_b_q <= 1'b0;
    end else begin
      sync_a_q <= raw_in;
      sync_b_q <= sync_a_q;
    end
  end

  // Debounce FSM with registered level, toggle, pulse and busy outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE_LOW;
      cnt_q        <= '0;
      sel_level_q  <= 1'b0;
      sel_toggle_q <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Pulses last one cycle unless an acceptance below sets them again.
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      case (state_q)
        IDLE_LOW: begin
          if (sync_b_q) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!sync_b_q) begin
            // Bounce: drop the candidate without touching the outputs.
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            state_q      <= IDLE_HIGH;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            sel_level_q  <= 1'b1;
            rise_pulse_q <= 1'b1;
            sel_toggle_q <= ~sel_toggle_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        IDLE_HIGH: begin
          if (!sync_b_q) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (sync_b_q) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            // A release changes the level but leaves the toggle alone.
            state_q      <= IDLE_LOW;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            sel_level_q  <= 1'b0;
            fall_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_level  = sel_level_q;
  assign sel_toggle = sel_toggle_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign busy       = busy_q;

endmodule
